// File: rtl/ccnt_run_sequencer_pkg.sv
// Shared definitions for the run sequencer: state encoding and default widths.
// State values are fixed (IDLE=0, EXEC=1, DONE=2) so external decoders agree.
package ccnt_run_sequencer_pkg;

   localparam int CTX_ADDR_W_DEF = 10;
   localparam int RUN_CYC_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } run_state_t;

endpackage

// File: rtl/ccnt_run_sequencer.sv
// Run-trigger responder: acknowledges a held trigger, then counts CCNT down to 0 with context enable.
// Latency: acknowledge 1 cycle after trigger sample; EN_I low freezes all state (no drops).
// SYNC_RESP_RUN_CYCLES_EN adds LAST_RUN_CYCLES_O, busy-cycle count of the last completed run.
module ccnt_run_sequencer
   import ccnt_run_sequencer_pkg::*;
#(
   parameter int CONTEXT_ADDR_WIDTH = CTX_ADDR_W_DEF,
   parameter int RUN_CYCLES_WIDTH   = RUN_CYC_W_DEF
) (
   input  logic                          CGRA_CLK_I,
   input  logic                          RST_N_I,
   input  logic                          EN_I,
   input  logic                          TRIGGER_RUN_I,
   input  logic [CONTEXT_ADDR_WIDTH-1:0] START_ADDR_I,
   input  logic                          IS_HYBRID_I,
   input  logic                          ABORT_I,
   input  logic                          CLEAR_ERR_I,
   output logic                          RUN_STARTED_O,
   output logic [CONTEXT_ADDR_WIDTH-1:0] CCNT_O,
   output logic                          CONTEXT_EN_O,
   output logic                          HYBRID_RUN_O,
   output logic                          RUN_DONE_O,
   output logic                          BUSY_O,
   output logic                          OVERRUN_O
`ifdef SYNC_RESP_RUN_CYCLES_EN
   ,
   output logic [RUN_CYCLES_WIDTH-1:0]   LAST_RUN_CYCLES_O
`endif
);

   run_state_t                    r_state;
   logic [CONTEXT_ADDR_WIDTH-1:0] r_ccnt;
   logic                          r_run_started;
   logic                          r_ctx_en;
   logic                          r_hybrid;
   logic                          r_run_done;
   logic                          r_busy;
   logic                          r_overrun;

   logic                          w_accept;
   logic                          w_ovr_evt;

   assign w_accept  = (r_state == ST_IDLE) && TRIGGER_RUN_I && !ABORT_I;
   // The requester still holds the trigger while it sees the acknowledge; that sample is benign.
   assign w_ovr_evt = (r_state != ST_IDLE) && TRIGGER_RUN_I && !r_run_started;

   always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         r_state       <= ST_IDLE;
         r_ccnt        <= '1;
         r_run_started <= 1'b0;
         r_ctx_en      <= 1'b0;
         r_hybrid      <= 1'b0;
         r_run_done    <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
      end else if (EN_I) begin
         r_run_started <= 1'b0;

         if (w_ovr_evt)
            r_overrun <= 1'b1;
         else if (CLEAR_ERR_I)
            r_overrun <= 1'b0;

         if ((r_state != ST_IDLE) && ABORT_I) begin
            r_state    <= ST_IDLE;
            r_ccnt     <= '1;
            r_ctx_en   <= 1'b0;
            r_hybrid   <= 1'b0;
            r_run_done <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_state       <= ST_EXEC;
                     r_ccnt        <= START_ADDR_I;
                     r_run_started <= 1'b1;
                     r_ctx_en      <= 1'b1;
                     r_hybrid      <= IS_HYBRID_I;
                     r_busy        <= 1'b1;
                  end
               end
               ST_EXEC: begin
                  if (r_ccnt != '0) begin
                     r_ccnt <= r_ccnt - CONTEXT_ADDR_WIDTH'(1);
                  end else begin
                     r_state    <= ST_DONE;
                     r_ctx_en   <= 1'b0;
                     r_run_done <= 1'b1;
                  end
               end
               ST_DONE: begin
                  r_state    <= ST_IDLE;
                  r_run_done <= 1'b0;
                  r_busy     <= 1'b0;
                  r_hybrid   <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign RUN_STARTED_O = r_run_started;
   assign CCNT_O        = r_ccnt;
   assign CONTEXT_EN_O  = r_ctx_en;
   assign HYBRID_RUN_O  = r_hybrid;
   assign RUN_DONE_O    = r_run_done;
   assign BUSY_O        = r_busy;
   assign OVERRUN_O     = r_overrun;

`ifdef SYNC_RESP_RUN_CYCLES_EN
   logic [RUN_CYCLES_WIDTH-1:0] r_run_cycles;
   logic [RUN_CYCLES_WIDTH-1:0] r_last_run_cycles;
   logic [RUN_CYCLES_WIDTH-1:0] w_cycles_inc;

   assign w_cycles_inc = (&r_run_cycles) ? r_run_cycles
                                         : r_run_cycles + RUN_CYCLES_WIDTH'(1);

   // Counts wall-clock busy cycles, so it keeps running while EN_I is low.
   always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         r_run_cycles      <= '0;
         r_last_run_cycles <= '0;
      end else begin
         if (EN_I && w_accept)
            r_run_cycles <= '0;
         else if (r_busy)
            r_run_cycles <= w_cycles_inc;

         if (EN_I && (r_state == ST_DONE) && !ABORT_I)
            r_last_run_cycles <= w_cycles_inc;
      end
   end

   assign LAST_RUN_CYCLES_O = r_last_run_cycles;
`endif

endmodule

// File: tb/tb_ccnt_run_sequencer.sv
// Bench for ccnt_run_sequencer: directed runs plus randomized runs checked against a
// run-position model (expected outputs derived from enabled cycles since acceptance).
module tb_ccnt_run_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       trig;
   logic [9:0] start_addr;
   logic       is_hyb;
   logic       abort;
   logic       clr;
   logic       run_started;
   logic [9:0] ccnt;
   logic       ctx_en;
   logic       hyb_run;
   logic       run_done;
   logic       busy;
   logic       overrun;
`ifdef SYNC_RESP_RUN_CYCLES_EN
   logic [15:0] last_cycles;
`endif

   int         n_cmp = 0;
   int         n_err = 0;
   bit         e_ovr;
   logic [9:0] e_idle_ccnt;
   int         e_last;

   always #5 clk = ~clk;

   ccnt_run_sequencer dut (
      .CGRA_CLK_I    (clk),
      .RST_N_I       (rst_n),
      .EN_I          (en),
      .TRIGGER_RUN_I (trig),
      .START_ADDR_I  (start_addr),
      .IS_HYBRID_I   (is_hyb),
      .ABORT_I       (abort),
      .CLEAR_ERR_I   (clr),
      .RUN_STARTED_O (run_started),
      .CCNT_O        (ccnt),
      .CONTEXT_EN_O  (ctx_en),
      .HYBRID_RUN_O  (hyb_run),
      .RUN_DONE_O    (run_done),
      .BUSY_O        (busy),
      .OVERRUN_O     (overrun)
`ifdef SYNC_RESP_RUN_CYCLES_EN
      ,
      .LAST_RUN_CYCLES_O (last_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit st, input logic [9:0] cc,
                             input bit ce, input bit hy, input bit dn, input bit bz);
      chk({tag, ".started"}, 32'(run_started), 32'(st));
      chk({tag, ".ccnt"},    32'(ccnt),        32'(cc));
      chk({tag, ".ctx_en"},  32'(ctx_en),      32'(ce));
      chk({tag, ".hybrid"},  32'(hyb_run),     32'(hy));
      chk({tag, ".done"},    32'(run_done),    32'(dn));
      chk({tag, ".busy"},    32'(busy),        32'(bz));
      chk({tag, ".overrun"}, 32'(overrun),     32'(e_ovr));
   endtask

   // Called at a negedge with the DUT idle. k counts enabled edges since the acceptance edge:
   // k=1..s+1 execute CCNT=s-k+1, k=s+2 is the done cycle, k=s+3 is back in idle.
   task automatic run(input string tag, input int s, input bit hyb, input int gap_pct,
                      input int ovr_at, input int abort_at, input int rst_at,
                      input int freeze_at, input bit hold);
      int k, gaps, fz, budget;
      bit ab, en_n, tr_n, fin;
      logic [9:0] cc;
      start_addr = 10'(s);
      is_hyb = hyb;
      trig = 1'b1;
      en = 1'b1;
      abort = 1'b0;
      @(posedge clk);
      k = 1; gaps = 0; fz = 0; ab = 1'b0; fin = 1'b0; budget = 0;
      while (!fin && budget < 4000) begin
         @(negedge clk);
         budget++;
         cc = 10'(s - k + 1);
         if (ab) begin
            check_outs({tag, ".abort"}, 0, 10'h3FF, 0, 0, 0, 0);
`ifdef SYNC_RESP_RUN_CYCLES_EN
            chk({tag, ".last_kept"}, 32'(last_cycles), 32'(e_last));
`endif
            e_idle_ccnt = 10'h3FF;
            fin = 1'b1;
         end else if (k <= s + 1) begin
            check_outs({tag, ".exec"}, k == 1, cc, 1, hyb, 0, 1);
         end else if (k == s + 2) begin
            check_outs({tag, ".done"}, 0, 10'h000, 0, hyb, 1, 1);
         end else begin
            check_outs({tag, ".idle"}, 0, 10'h000, 0, 0, 0, 0);
`ifdef SYNC_RESP_RUN_CYCLES_EN
            e_last = s + 2 + gaps;
            chk({tag, ".last_cycles"}, 32'(last_cycles), 32'(e_last));
`endif
            e_idle_ccnt = 10'h000;
            fin = 1'b1;
         end
         if (fin) break;

         if (rst_at >= 0 && k >= 2 && k <= s + 1 && int'(cc) == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            e_ovr = 1'b0;
            e_last = 0;
            check_outs({tag, ".async_rst"}, 0, 10'h3FF, 0, 0, 0, 0);
`ifdef SYNC_RESP_RUN_CYCLES_EN
            chk({tag, ".rst_last"}, 32'(last_cycles), 32'(0));
`endif
            trig = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            e_idle_ccnt = 10'h3FF;
            return;
         end

         en_n = ($urandom_range(99) >= gap_pct);
         if (freeze_at >= 0 && k >= 2 && k <= s + 1 && int'(cc) == freeze_at && fz < 3) begin
            en_n = 1'b0;
            fz++;
         end
         tr_n = hold || (k == 1) ||
                (ovr_at >= 0 && k >= 2 && k <= s + 1 && int'(cc) == ovr_at);
         ab = (abort_at >= 0 && k >= 2 && k <= s + 1 && int'(cc) == abort_at);
         if (ab) en_n = 1'b1;
         en = en_n;
         trig = tr_n;
         abort = ab;
         @(posedge clk);
         if (en_n) begin
            if (tr_n && k >= 2 && k <= s + 2) e_ovr = 1'b1;
            if (!ab) k++;
         end else if (k <= s + 2) begin
            gaps++;
         end
      end
      if (!fin) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s.timeout: observed no completion expected completion", tag);
      end
      abort = 1'b0;
      en = 1'b1;
      trig = hold;
   endtask

   task automatic clear_err();
      clr = 1'b1;
      en = 1'b1;
      @(posedge clk);
      e_ovr = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      check_outs("clear_err", 0, e_idle_ccnt, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b1;
      trig = 1'b0;
      start_addr = '0;
      is_hyb = 1'b0;
      abort = 1'b0;
      clr = 1'b0;
      e_ovr = 1'b0;
      e_idle_ccnt = 10'h3FF;
      e_last = 0;
      repeat (2) @(negedge clk);
      check_outs("reset", 0, 10'h3FF, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_outs("post_reset_idle", 0, 10'h3FF, 0, 0, 0, 0);

      run("park_3ff", 1023, 0, 0, -1, -1, -1, -1, 0);
      run("hyb5", 5, 1, 0, -1, -1, -1, -1, 0);
      run("zero_hold", 0, 0, 0, -1, -1, -1, -1, 1);
      run("after_done", 3, 1, 0, -1, -1, -1, -1, 0);
      clear_err();
      run("ovr20", 20, 0, 0, 12, -1, -1, -1, 0);
      clear_err();
      run("freeze20", 20, 0, 0, -1, -1, -1, 10, 0);
      run("abort7", 20, 1, 0, -1, 7, -1, -1, 0);

      // Abort asserted in idle must block the trigger sampled on that edge.
      trig = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outs("idle_abort_blocks", 0, e_idle_ccnt, 0, 0, 0, 0);
      trig = 1'b0;
      abort = 1'b0;

      run("rst_mid", 30, 1, 0, -1, -1, 9, -1, 0);
      run("after_rst", 2, 0, 0, -1, -1, -1, -1, 0);

      for (int i = 0; i < 12; i++) begin
         int s, oa, aa;
         s  = $urandom_range(40);
         oa = ($urandom_range(2) == 0) ? int'($urandom_range(s)) : -1;
         aa = ($urandom_range(3) == 0) ? int'($urandom_range(s)) : -1;
         run("rand", s, 1'($urandom_range(1)), 25, oa, aa, -1, -1, 0);
         if (e_ovr) clear_err();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
